// File: rtl/sbh_pkg.sv
// Shared sign-bit-hiding types: coefficient-group geometry, scanner states and the per-CG summary
// record handed from the scanner to the hide decision.
package sbh_pkg;

    localparam int CG_SIZE = 16;
    localparam int COEFF_W = 16;

    typedef logic [3:0] cg_idx_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } sbh_scan_state_e;

    typedef struct packed {
        cg_idx_t first_nz;
        cg_idx_t last_nz;
        logic    parity;
        logic    last_nz_sign;
        logic    all_zero;
    } sbh_cg_summary_t;

    localparam sbh_cg_summary_t SUMMARY_RESET = '{
        first_nz:     4'd0,
        last_nz:      4'd0,
        parity:       1'b0,
        last_nz_sign: 1'b0,
        all_zero:     1'b0
    };

endpackage

// File: rtl/sbh_cg_scanner_if.sv
// Coefficient stream into the CG scanner and the per-CG summary coming back out of it.
// The producer side is the master; the scanner is the slave.
interface sbh_cg_scanner_if
    import sbh_pkg::*;
#(
    parameter int COEFF_W = 16
);

    logic                      coeff_valid;
    logic                      cg_start;
    logic signed [COEFF_W-1:0] coeff_in;

    logic                      valid_out;
    cg_idx_t                   firstNZ_out;
    cg_idx_t                   lastNZ_out;
    logic                      parity_out;
    logic                      lastNZ_sign_out;
    logic                      all_zero_out;
    logic                      seq_err_out;

    modport master (
        output coeff_valid,
        output cg_start,
        output coeff_in,
        input  valid_out,
        input  firstNZ_out,
        input  lastNZ_out,
        input  parity_out,
        input  lastNZ_sign_out,
        input  all_zero_out,
        input  seq_err_out
    );

    modport slave (
        input  coeff_valid,
        input  cg_start,
        input  coeff_in,
        output valid_out,
        output firstNZ_out,
        output lastNZ_out,
        output parity_out,
        output lastNZ_sign_out,
        output all_zero_out,
        output seq_err_out
    );

endinterface

// File: rtl/sbh_cg_scanner.sv
// Serial front end of the sign-bit-hiding unit: folds the 16 scan-ordered coefficients of one
// coefficient group into first/last nonzero index, level-sum parity and last-nonzero sign.
module sbh_cg_scanner
    import sbh_pkg::*;
#(
    parameter int COEFF_W = sbh_pkg::COEFF_W,
    parameter int CG_SIZE = sbh_pkg::CG_SIZE
) (
    input  logic             clk,
    input  logic             rst_n,
    sbh_cg_scanner_if.slave  scan_if
);

    localparam cg_idx_t LAST_IDX = cg_idx_t'(CG_SIZE - 1);

    sbh_scan_state_e state_q, state_d;
    cg_idx_t         idx_q, idx_d;

    logic            seen_q, seen_d;
    cg_idx_t         first_q, first_d;
    cg_idx_t         last_q, last_d;
    logic            parity_q, parity_d;
    logic            sign_q, sign_d;

    sbh_cg_summary_t summary_q, summary_d;
    logic            valid_q, valid_d;
    logic            seq_err_q, seq_err_d;

    logic            restart;
    logic            nz;
    cg_idx_t         beat_idx;
    logic            base_seen;
    cg_idx_t         base_first;
    cg_idx_t         base_last;
    logic            base_parity;
    logic            base_sign;
    logic            upd_seen;
    cg_idx_t         upd_first;
    cg_idx_t         upd_last;
    logic            upd_parity;
    logic            upd_sign;

    // An index-0 beat folds into cleared accumulators, so a new CG never needs a separate clear cycle.
    always_comb begin
        restart     = scan_if.coeff_valid & scan_if.cg_start;
        nz          = (scan_if.coeff_in != '0);
        beat_idx    = restart ? cg_idx_t'(0) : idx_q;
        base_seen   = restart ? 1'b0 : seen_q;
        base_first  = restart ? cg_idx_t'(0) : first_q;
        base_last   = restart ? cg_idx_t'(0) : last_q;
        base_parity = restart ? 1'b0 : parity_q;
        base_sign   = restart ? 1'b0 : sign_q;

        upd_seen    = base_seen | nz;
        upd_first   = (nz && !base_seen) ? beat_idx : base_first;
        upd_last    = nz ? beat_idx : base_last;
        upd_sign    = nz ? scan_if.coeff_in[COEFF_W-1] : base_sign;
        upd_parity  = base_parity ^ scan_if.coeff_in[0];
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        seen_d    = seen_q;
        first_d   = first_q;
        last_d    = last_q;
        parity_d  = parity_q;
        sign_d    = sign_q;
        summary_d = summary_q;
        valid_d   = 1'b0;
        seq_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (scan_if.coeff_valid) begin
                    if (scan_if.cg_start) begin
                        seen_d   = upd_seen;
                        first_d  = upd_first;
                        last_d   = upd_last;
                        parity_d = upd_parity;
                        sign_d   = upd_sign;
                        idx_d    = cg_idx_t'(1);
                        state_d  = ACCUM;
                    end else begin
                        seq_err_d = 1'b1;
                    end
                end
            end

            ACCUM: begin
                if (scan_if.coeff_valid) begin
                    seen_d   = upd_seen;
                    first_d  = upd_first;
                    last_d   = upd_last;
                    parity_d = upd_parity;
                    sign_d   = upd_sign;
                    if (scan_if.cg_start) begin
                        // Early cg_start abandons the partial CG and restarts on this beat.
                        seq_err_d = 1'b1;
                        idx_d     = cg_idx_t'(1);
                    end else if (idx_q == LAST_IDX) begin
                        valid_d   = 1'b1;
                        summary_d = '{
                            first_nz:     upd_first,
                            last_nz:      upd_last,
                            parity:       upd_parity,
                            last_nz_sign: upd_sign,
                            all_zero:     !upd_seen
                        };
                        idx_d     = cg_idx_t'(0);
                        state_d   = IDLE;
                    end else begin
                        idx_d = idx_q + cg_idx_t'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
                idx_d   = cg_idx_t'(0);
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            seen_q    <= 1'b0;
            first_q   <= '0;
            last_q    <= '0;
            parity_q  <= 1'b0;
            sign_q    <= 1'b0;
            summary_q <= SUMMARY_RESET;
            valid_q   <= 1'b0;
            seq_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            seen_q    <= seen_d;
            first_q   <= first_d;
            last_q    <= last_d;
            parity_q  <= parity_d;
            sign_q    <= sign_d;
            summary_q <= summary_d;
            valid_q   <= valid_d;
            seq_err_q <= seq_err_d;
        end
    end

    assign scan_if.valid_out       = valid_q;
    assign scan_if.firstNZ_out     = summary_q.first_nz;
    assign scan_if.lastNZ_out      = summary_q.last_nz;
    assign scan_if.parity_out      = summary_q.parity;
    assign scan_if.lastNZ_sign_out = summary_q.last_nz_sign;
    assign scan_if.all_zero_out    = summary_q.all_zero;
    assign scan_if.seq_err_out     = seq_err_q;

endmodule

// File: tb/tb_sbh_cg_scanner.sv
// Directed bench for sbh_cg_scanner: expected summaries and error pulses are queued with the cycle
// they must appear in, and a negedge monitor checks every cycle against those queues.
module tb_sbh_cg_scanner;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_cmp;
    int   n_err;
    logic mon_en;

    typedef struct {
        int         at_cyc;
        logic [3:0] first_nz;
        logic [3:0] last_nz;
        logic       parity;
        logic       sign;
        logic       all_zero;
    } exp_t;

    exp_t sb[$];
    int   err_q[$];
    exp_t mon_e;
    logic mon_v;

    logic signed [15:0] cg_buf [16];

    sbh_cg_scanner_if #(.COEFF_W(16)) scan_if ();

    sbh_cg_scanner #(
        .COEFF_W(16),
        .CG_SIZE(16)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .scan_if(scan_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        n_cmp++;
        assert (obs === expd) else begin
            n_err++;
            $error("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, expd, cyc);
        end
    endtask

    task automatic apply_stimulus(input logic v, input logic s, input logic signed [15:0] c);
        scan_if.coeff_valid = v;
        scan_if.cg_start    = s;
        scan_if.coeff_in    = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) apply_stimulus(1'b0, 1'b0, 16'sd0);
    endtask

    task automatic clear_cg();
        for (int i = 0; i < 16; i++) cg_buf[i] = 16'sd0;
    endtask

    // Reference summary built from magnitudes, independent of the LSB-parity shortcut in the design.
    task automatic push_expected(input int at_cyc);
        exp_t e;
        int   sum;
        int   v;
        logic found;
        e.at_cyc   = at_cyc;
        e.first_nz = 4'd0;
        e.last_nz  = 4'd0;
        e.sign     = 1'b0;
        sum        = 0;
        found      = 1'b0;
        for (int i = 0; i < 16; i++) begin
            v = int'(cg_buf[i]);
            if (v != 0) begin
                if (!found) e.first_nz = 4'(i);
                found     = 1'b1;
                e.last_nz = 4'(i);
                e.sign    = (v < 0);
            end
            sum += (v < 0) ? -v : v;
        end
        e.parity   = sum[0];
        e.all_zero = !found;
        sb.push_back(e);
    endtask

    task automatic send_cg(input logic with_bubbles);
        for (int i = 0; i < 16; i++) begin
            if (with_bubbles && $urandom_range(0, 2) == 0)
                repeat ($urandom_range(1, 2)) apply_stimulus(1'b0, 1'b0, 16'($urandom));
            if (i == 15) push_expected(cyc + 1);
            apply_stimulus(1'b1, i == 0, cg_buf[i]);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            mon_v = (sb.size() > 0) && (sb[0].at_cyc == cyc);
            check_output("valid_out", 32'(scan_if.valid_out), 32'(mon_v));
            if (mon_v) begin
                mon_e = sb.pop_front();
                check_output("firstNZ", 32'(scan_if.firstNZ_out), 32'(mon_e.first_nz));
                check_output("lastNZ", 32'(scan_if.lastNZ_out), 32'(mon_e.last_nz));
                check_output("parity", 32'(scan_if.parity_out), 32'(mon_e.parity));
                check_output("lastNZ_sign", 32'(scan_if.lastNZ_sign_out), 32'(mon_e.sign));
                check_output("all_zero", 32'(scan_if.all_zero_out), 32'(mon_e.all_zero));
            end
            mon_v = (err_q.size() > 0) && (err_q[0] == cyc);
            check_output("seq_err_out", 32'(scan_if.seq_err_out), 32'(mon_v));
            if (mon_v) void'(err_q.pop_front());
        end
    end

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        scan_if.coeff_valid = 1'b0;
        scan_if.cg_start    = 1'b0;
        scan_if.coeff_in    = 16'sd0;
        repeat (3) @(posedge clk);
        #1;
        check_output("rst_valid", 32'(scan_if.valid_out), 32'd0);
        check_output("rst_summary", {25'd0, scan_if.firstNZ_out, scan_if.lastNZ_out,
                     scan_if.parity_out, scan_if.lastNZ_sign_out, scan_if.all_zero_out}, 32'd0);
        check_output("rst_seq_err", 32'(scan_if.seq_err_out), 32'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        idle(2);

        $display("[TB] mixed-sign CG");
        clear_cg();
        cg_buf[2] = 16'sd3; cg_buf[6] = -16'sd2; cg_buf[13] = 16'sd1; cg_buf[15] = -16'sd5;
        send_cg(1'b0);
        idle(3);

        $display("[TB] all-zero CG");
        clear_cg();
        send_cg(1'b0);
        idle(2);

        $display("[TB] back-to-back CGs, no bubbles");
        clear_cg();
        cg_buf[0] = 16'sd4; cg_buf[5] = -16'sd7; cg_buf[12] = 16'sd2;
        send_cg(1'b0);
        clear_cg();
        cg_buf[1] = -16'sd1; cg_buf[3] = 16'sd6; cg_buf[14] = -16'sd3;
        send_cg(1'b0);
        idle(2);

        $display("[TB] back-to-back CGs with bubbles");
        for (int k = 0; k < 3; k++) begin
            clear_cg();
            for (int i = 0; i < 16; i++)
                if ($urandom_range(0, 2) == 0) cg_buf[i] = 16'($signed($urandom_range(0, 40)) - 20);
            send_cg(1'b1);
        end
        idle(2);

        $display("[TB] hide-candidate CG");
        clear_cg();
        cg_buf[2] = 16'sd1; cg_buf[15] = 16'sd2;
        send_cg(1'b1);
        idle(2);

        $display("[TB] most-negative level");
        clear_cg();
        cg_buf[7] = -16'sd32767 - 16'sd1;
        send_cg(1'b0);
        idle(2);

        $display("[TB] cg_start at index 9");
        clear_cg();
        for (int i = 0; i < 9; i++) apply_stimulus(1'b1, i == 0, 16'sd9);
        err_q.push_back(cyc + 1);
        cg_buf[4] = -16'sd8; cg_buf[10] = 16'sd3;
        send_cg(1'b0);
        idle(2);

        $display("[TB] stray beat in IDLE");
        err_q.push_back(cyc + 1);
        apply_stimulus(1'b1, 1'b0, 16'sd7);
        idle(2);
        clear_cg();
        cg_buf[0] = 16'sd1;
        send_cg(1'b0);
        idle(2);

        $display("[TB] reset at index 8");
        clear_cg();
        cg_buf[3] = -16'sd2;
        send_cg(1'b0);
        idle(2);
        for (int i = 0; i < 8; i++) apply_stimulus(1'b1, i == 0, 16'sd5);
        rst_n = 1'b0;
        scan_if.coeff_valid = 1'b0;
        scan_if.cg_start    = 1'b0;
        #1;
        check_output("midrst_valid", 32'(scan_if.valid_out), 32'd0);
        check_output("midrst_summary", {25'd0, scan_if.firstNZ_out, scan_if.lastNZ_out,
                     scan_if.parity_out, scan_if.lastNZ_sign_out, scan_if.all_zero_out}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);
        clear_cg();
        cg_buf[5] = 16'sd1; cg_buf[11] = -16'sd4;
        send_cg(1'b0);
        idle(2);

        for (int k = 0; k < 20 && (sb.size() > 0 || err_q.size() > 0); k++) @(posedge clk);
        check_output("summaries_pending", 32'(sb.size()), 32'd0);
        check_output("seq_err_pending", 32'(err_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
